// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: per-cycle round-robin with bounded bus lock, registered
// memory command and a two-stage {valid, port} tag pipe that steers read data back.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              last_q, last_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              tag_valid_q, tag_valid_d;
    logic              tag_port_q, tag_port_d;
    logic              ret_valid_q, ret_valid_d;
    logic              ret_port_q, ret_port_d;

    logic grant;
    logic win;
    logic held_port;
    logic held_req;
    logic held_lock;
    logic released;
    logic idle_win;

    // Arbitration: a lock that has used up MAX_LOCK grants falls back to plain
    // round-robin, and since last_q already names the locked port the other side wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        last_d     = last_q;
        grant      = 1'b0;
        win        = 1'b0;
        held_port  = (state_q == LOCK1);
        held_req   = held_port ? req1 : req0;
        held_lock  = held_port ? lock1 : lock0;
        released   = (lock_cnt_q == CNT_W'(MAX_LOCK));
        idle_win   = (req0 && req1) ? ~last_q : req1;

        if (state_q == IDLE || released) begin
            if (req0 || req1) begin
                grant = 1'b1;
                win   = idle_win;
                if (idle_win ? lock1 : lock0) begin
                    state_d    = idle_win ? LOCK1 : LOCK0;
                    lock_cnt_d = CNT_W'(1);
                end else begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end
            end else begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        end else if (held_req) begin
            grant = 1'b1;
            win   = held_port;
            if (held_lock) begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
            end else begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        end else begin
            state_d    = IDLE;
            lock_cnt_d = '0;
        end

        if (grant) begin
            last_d = win;
        end
    end

    always_comb begin
        mem_en_d    = grant;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (grant) begin
            mem_rw_d    = win ? rw1 : rw0;
            mem_addr_d  = win ? addr1 : addr0;
            mem_wdata_d = win ? wdata1 : wdata0;
        end
        tag_valid_d = grant && (win ? rw1 : rw0);
        tag_port_d  = win;
        ret_valid_d = tag_valid_q;
        ret_port_d  = tag_port_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_cnt_q  <= '0;
            last_q      <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_valid_q <= 1'b0;
            tag_port_q  <= 1'b0;
            ret_valid_q <= 1'b0;
            ret_port_q  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            last_q      <= last_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag_valid_q <= tag_valid_d;
            tag_port_q  <= tag_port_d;
            ret_valid_q <= ret_valid_d;
            ret_port_q  <= ret_port_d;
        end
    end

    assign gnt0      = grant && !win && !reset;
    assign gnt1      = grant && win && !reset;
    assign mem_en    = mem_en_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rvalid0   = ret_valid_q && !ret_port_q;
    assign rvalid1   = ret_valid_q && ret_port_q;
    assign rdata0    = mem_rdata;
    assign rdata1    = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: requester queues drive the ports, accepted
// transactions push expected commands/read returns that are popped when due.
module tb_mem_bus_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int MAX_LOCK = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req0, req1, lock0, lock1, rw0, rw1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_en, mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Synchronous-read memory: unwritten locations read back init_val(addr).
    logic [7:0] mem_store [0:65535];
    logic       mem_wr    [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rw) begin
                mem_rdata <= (mem_wr[mem_addr] === 1'b1) ? mem_store[mem_addr] : init_val(mem_addr);
            end else begin
                mem_store[mem_addr] <= mem_wdata;
                mem_wr[mem_addr]    <= 1'b1;
            end
        end
    end

    typedef struct {
        logic        rw;
        logic        lock;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    typedef struct {
        int          due;
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    typedef struct {
        int         due;
        logic [7:0] data;
    } rd_t;

    txn_t       pq0[$], pq1[$];
    cmd_t       cq[$];
    rd_t        rq0[$], rq1[$];
    logic [1:0] gq[$];
    logic [7:0] shadow [int];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic txn_t rd(input logic [15:0] a, input logic lk);
        txn_t t;
        t.rw = 1'b1; t.lock = lk; t.addr = a; t.wdata = 8'h00;
        return t;
    endfunction

    task automatic drive();
        req0 = (pq0.size() != 0);
        req1 = (pq1.size() != 0);
        if (req0) begin
            lock0 = pq0[0].lock; rw0 = pq0[0].rw; addr0 = pq0[0].addr; wdata0 = pq0[0].wdata;
        end else begin
            lock0 = 1'b0; rw0 = 1'b1; addr0 = '0; wdata0 = '0;
        end
        if (req1) begin
            lock1 = pq1[0].lock; rw1 = pq1[0].rw; addr1 = pq1[0].addr; wdata1 = pq1[0].wdata;
        end else begin
            lock1 = 1'b0; rw1 = 1'b1; addr1 = '0; wdata1 = '0;
        end
    endtask

    task automatic accept(input bit port, input txn_t t);
        cmd_t c;
        rd_t  r;
        c.due = cyc + 1; c.rw = t.rw; c.addr = t.addr; c.wdata = t.wdata;
        cq.push_back(c);
        if (t.rw) begin
            r.due  = cyc + 2;
            r.data = shadow.exists(int'(t.addr)) ? shadow[int'(t.addr)] : init_val(t.addr);
            if (port) rq1.push_back(r);
            else      rq0.push_back(r);
        end else begin
            shadow[int'(t.addr)] = t.wdata;
        end
    endtask

    // One bus cycle: sample on the falling edge, retire due expectations, then
    // advance any requester whose request was granted.
    task automatic cycle();
        logic [1:0] eg;
        logic       ev;
        cmd_t       c;
        rd_t        r;
        @(negedge clk);
        eg = (gq.size() != 0) ? gq.pop_front() : 2'b00;
        check("gnt", 32'({gnt1, gnt0}), 32'(eg));

        ev = (cq.size() != 0) && (cq[0].due == cyc);
        check("mem_en", 32'(mem_en), 32'(ev));
        if (ev) begin
            c = cq.pop_front();
            check("mem_rw", 32'(mem_rw), 32'(c.rw));
            check("mem_addr", 32'(mem_addr), 32'(c.addr));
            if (!c.rw) check("mem_wdata", 32'(mem_wdata), 32'(c.wdata));
        end

        ev = (rq0.size() != 0) && (rq0[0].due == cyc);
        check("rvalid0", 32'(rvalid0), 32'(ev));
        if (ev) begin
            r = rq0.pop_front();
            check("rdata0", 32'(rdata0), 32'(r.data));
        end
        ev = (rq1.size() != 0) && (rq1[0].due == cyc);
        check("rvalid1", 32'(rvalid1), 32'(ev));
        if (ev) begin
            r = rq1.pop_front();
            check("rdata1", 32'(rdata1), 32'(r.data));
        end

        if (gnt0 && pq0.size() != 0) accept(1'b0, pq0.pop_front());
        if (gnt1 && pq1.size() != 0) accept(1'b1, pq1.pop_front());

        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        cq.delete(); rq0.delete(); rq1.delete(); gq.delete();
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_rw", 32'(mem_rw), 32'd1);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive();
    endtask

    initial begin
        txn_t w;
        drive();
        #2;
        do_reset();

        // Single read from port 0: grant, command and return latency.
        pq0.push_back(rd(16'h1234, 1'b0));
        gq.push_back(2'b01);
        drive();
        repeat (4) cycle();

        // Both ports requesting without lock alternate, port 0 first after reset.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pq0.push_back(rd(16'h2000 + 16'(i), 1'b0));
            pq1.push_back(rd(16'h3000 + 16'(i), 1'b0));
            gq.push_back(2'b01);
            gq.push_back(2'b10);
        end
        drive();
        repeat (8) cycle();

        // Port 0 holding lock against a waiting port 1: four grants, forced release.
        do_reset();
        for (int i = 0; i < 5; i++) pq0.push_back(rd(16'h4000 + 16'(i), 1'b1));
        pq1.push_back(rd(16'h5000, 1'b0));
        repeat (4) gq.push_back(2'b01);
        gq.push_back(2'b10);
        gq.push_back(2'b01);
        drive();
        repeat (9) cycle();

        // Port 1 write interleaved with port 0 reads; second read observes the write.
        do_reset();
        pq0.push_back(rd(16'h0100, 1'b0));
        pq0.push_back(rd(16'h00FF, 1'b0));
        w.rw = 1'b0; w.lock = 1'b0; w.addr = 16'h00FF; w.wdata = 8'h5A;
        pq1.push_back(w);
        gq.push_back(2'b01);
        gq.push_back(2'b10);
        gq.push_back(2'b01);
        drive();
        repeat (6) cycle();

        // Reset while reads are in flight: outputs drop at once, dropped reads never return.
        do_reset();
        pq0.push_back(rd(16'h0042, 1'b0));
        pq0.push_back(rd(16'h0043, 1'b0));
        gq.push_back(2'b01);
        gq.push_back(2'b01);
        drive();
        repeat (2) cycle();
        pq1.push_back(rd(16'h0077, 1'b0));
        drive();
        #1;
        check("pre_rst_rvalid0", 32'(rvalid0), 32'd1);
        check("pre_rst_mem_en", 32'(mem_en), 32'd1);
        check("pre_rst_gnt1", 32'(gnt1), 32'd1);
        do_reset();
        pq0.push_back(rd(16'h0010, 1'b0));
        gq.push_back(2'b01);
        gq.push_back(2'b10);
        drive();
        repeat (6) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
